shift_result_queue: RTL and testbench
=====================================

# shift_result_queue

Result-capture stage directly downstream of the ShiftLR barrel shifter in the Mosaic functional unit. Tracks each shift issued into the shifter's 1-cycle pipeline and captures the shifter output Z on the cycle it becomes valid. Buffers results with their tags in a small FIFO and presents them on a valid/ready port to writeback. Throttles issue through a credit-style `in_ready` so that no result the shifter produces is ever lost.

## Interface
Parameters:
- `WIDTH`, 32: data width; matches the shifter's X/Z width.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `TAG_W`, 4: width of the destination/sequence tag carried alongside each result.

Ports:
- `clock`  in  1  rising-edge clock, shared with ShiftLR.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  issue side presents a shift to ShiftLR this cycle.
- `in_tag`  in  TAG_W  tag for the issued shift.
- `in_ready`  out  1  block can accept an issue this cycle.
- `flush`  in  1  synchronous discard of all queued and in-flight results.
- `shift_z`  in  WIDTH  ShiftLR `Z` output.
- `out_valid`  out  1  head entry valid.
- `out_data`  out  WIDTH  head result.
- `out_tag`  out  TAG_W  head tag.
- `out_ready`  in  1  writeback consumes the head.
- `count`  out  $clog2(DEPTH+1)  occupied FIFO entries; does not include the in-flight result.
- `out_zero`  out  1  head result is all zeros. Present only with `SHIFTQ_ZFLAG_EN`.

## Operation
- Issue handshake: a shift is issued at edge E when `in_valid && in_ready`. ShiftLR registers its operands at the same edge E.
- In-flight register:
  - `pend_v` and `pend_tag` load `in_valid && in_ready` and `in_tag` at edge E.
  - At edge E+1, when `pend_v` is set, `shift_z` and `pend_tag` are written at the FIFO tail.
- Credit rule: `in_ready = !flush && (count + pend_v < DEPTH)`.
  - Uses registered state only; a pop in the same cycle does not raise `in_ready`.
  - Because of this rule a write never meets a full FIFO. No overflow path exists.
- Pop: the head is removed at an edge where `out_valid && out_ready`.
  - `out_valid = (count != 0)`.
  - `out_data` and `out_tag` come from registered head storage, not from `shift_z`.
- Simultaneous write and pop: `count` is unchanged, and both pointers advance.
- Pointers: log2(DEPTH) bits each and wrap naturally. `count` distinguishes full from empty.
- Flush:
  - At an edge with `flush=1`: `count`, both pointers and `pend_v` clear, and any pending write is dropped.
  - A pop in the same cycle is ignored.
  - An issue is impossible in the flush cycle because `in_ready` is 0.
- `out_valid` is held until the pop; `out_data` and `out_tag` are stable while `out_valid && !out_ready`.
- Reset while asserted: `out_valid=0`, `in_ready=0`, `count=0`, `pend_v=0`, `out_zero=0`. `out_data` and `out_tag` read 0.
- Reset release: `in_ready=1` in the first cycle after release.
- Mid-operation reset: queued and in-flight results are discarded. ShiftLR output in the first cycle after release is ignored because `pend_v=0`.

## Timing
- Issue to `out_valid`: 2 cycles minimum when the FIFO is empty. Issue at edge E, write at E+1, `out_valid` high after E+1.
- Sustained throughput: one result per cycle with `out_ready` held high and `DEPTH>=2`.
- `in_ready` drops after DEPTH outstanding results (queued plus in-flight) with no pops.
- `in_ready` returns high in the cycle after the pop edge that frees a slot.
- All outputs are registered or derived from registers. There is no combinational path from `in_valid`, `out_ready` or `shift_z` to any output.

## Configuration
- `SHIFTQ_ZFLAG_EN` defined:
  - Each FIFO entry stores an extra bit, computed as `shift_z == 0` at capture time.
  - The bit is driven on `out_zero` with the same timing as `out_data`.
  - `out_zero` resets to 0.
- `SHIFTQ_ZFLAG_EN` undefined: the `out_zero` port and its storage bit are absent. All other behaviour is identical.

## Test plan
- Single issue: reset, then `in_valid=1`, `in_tag=3`, ShiftLR X=0x8000_0000, S=4, arithmetic right. Required: `out_valid` rises 2 cycles after issue, `out_data=0xF800_0000`, `out_tag=3`, `count=1`.
- Streaming: 32 issues with random X and S=0..31 stepping, `out_ready=1`. Required: results emerge in order, match the golden `<<`, `>>` and `>>>` models, and `count` never exceeds 1.
- Backpressure: `out_ready=0`, issue every cycle. Required:
  - `in_ready` deasserts after exactly DEPTH=4 accepted issues and `count` settles at 4.
  - After one pop, exactly one further issue is accepted.
- Simultaneous events: queue holds 2 entries and a result is in flight; pop and write happen in the same cycle. Required: `count` stays 2 and tag order is preserved across pointer wrap after 10 such cycles.
- Flush: queue holds 3 entries plus 1 in flight; pulse `flush` together with `out_ready=1`. Required:
  - Next cycle: `count=0`, `out_valid=0`, and no stray write from the in-flight result.
  - `in_ready=0` during the flush cycle and 1 after it.
- Reset and zero flag: assert `reset_n=0` with the queue half full. Required: all outputs 0 immediately (asynchronously). With `SHIFTQ_ZFLAG_EN` defined, X=0x0000_0001 shifted right by 1 gives `out_zero=1`.

Source files
------------

// File: rtl/shift_result_queue_if.sv
// rtl/shift_result_queue_if.sv - issue, capture and writeback signals of the shift result queue (SHIFTQ_ZFLAG_EN adds out_zero)
interface shift_result_queue_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             in_valid;
   logic [TAG_W-1:0] in_tag;
   logic             in_ready;
   logic             flush;
   logic [WIDTH-1:0] shift_z;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_ready;
   logic [CNT_W-1:0] count;
`ifdef SHIFTQ_ZFLAG_EN
   logic             out_zero;
`endif

   // Issue side, shifter output and writeback consumer
   modport master (
      output in_valid, in_tag, flush, shift_z, out_ready,
      input  in_ready, out_valid, out_data, out_tag, count
`ifdef SHIFTQ_ZFLAG_EN
      , input out_zero
`endif
   );

   // The result queue itself
   modport slave (
      input  in_valid, in_tag, flush, shift_z, out_ready,
      output in_ready, out_valid, out_data, out_tag, count
`ifdef SHIFTQ_ZFLAG_EN
      , output out_zero
`endif
   );
endinterface

// File: rtl/shift_result_queue.sv
// rtl/shift_result_queue.sv - captures ShiftLR results into a tagged credit-throttled FIFO (optional SHIFTQ_ZFLAG_EN zero flag)
module shift_result_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   shift_result_queue_if.slave q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem  [DEPTH];
`ifdef SHIFTQ_ZFLAG_EN
   logic [DEPTH-1:0] zero_mem;
`endif

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pend_v_q, pend_v_d;
   logic [TAG_W-1:0] pend_tag_q, pend_tag_d;

   logic out_valid;
   logic in_ready;
   logic issue;
   logic do_write;
   logic do_pop;

   // Credit counts the in-flight result so the capture write can never find the FIFO full;
   // reset_n gating keeps in_ready low while reset is held and high right after release.
   assign in_ready  = reset_n && !q.flush
                      && (({1'b0, count_q} + (CNT_W + 1)'(pend_v_q)) < DEPTH_L);
   assign out_valid = (count_q != '0);
   assign issue     = q.in_valid && in_ready;
   assign do_write  = pend_v_q && !q.flush;
   assign do_pop    = out_valid && q.out_ready && !q.flush;

   // Next-state for pointers, occupancy and the in-flight slot; flush wins over everything
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pend_v_d   = issue;
      pend_tag_d = issue ? q.in_tag : pend_tag_q;
      if (q.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         pend_v_d = 1'b0;
      end else begin
         if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_write, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pend_v_q   <= 1'b0;
         pend_tag_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pend_v_q   <= pend_v_d;
         pend_tag_q <= pend_tag_d;
      end
   end

   // Capture the shifter output one edge after issue; storage needs no reset since count guards it
   always_ff @(posedge clock) begin
      if (do_write) begin
         data_mem[wr_ptr_q] <= q.shift_z;
         tag_mem[wr_ptr_q]  <= pend_tag_q;
`ifdef SHIFTQ_ZFLAG_EN
         zero_mem[wr_ptr_q] <= (q.shift_z == '0);
`endif
      end
   end

   // Head is masked while empty so outputs read zero during and after reset
   assign q.in_ready  = in_ready;
   assign q.out_valid = out_valid;
   assign q.out_data  = out_valid ? data_mem[rd_ptr_q] : '0;
   assign q.out_tag   = out_valid ? tag_mem[rd_ptr_q] : '0;
   assign q.count     = count_q;
`ifdef SHIFTQ_ZFLAG_EN
   assign q.out_zero  = out_valid && zero_mem[rd_ptr_q];
`endif
endmodule

// File: tb/tb_shift_result_queue.sv
// tb/tb_shift_result_queue.sv - randomized reference-model bench for shift_result_queue
module tb_shift_result_queue;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   shift_result_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) qif ();

   shift_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .q       (qif)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: queued results, one in-flight result
   logic [WIDTH-1:0] mq_data[$];
   logic [TAG_W-1:0] mq_tag[$];
   logic             m_pend = 1'b0;
   logic [WIDTH-1:0] m_pend_res;
   logic [TAG_W-1:0] m_pend_tag;

   // Operands of the shift offered this cycle
   logic [WIDTH-1:0] nx;
   logic [4:0]       ns;
   int               nop;

   int accepted;
   int max_count;

   function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] x, input logic [4:0] s,
                                               input int op);
      case (op)
         0:       return x << s;
         1:       return x >> s;
         default: return $unsigned($signed(x) >>> s);
      endcase
   endfunction

   task automatic drive(input logic v, input logic rdy);
      qif.in_valid  = v;
      qif.in_tag    = TAG_W'($urandom);
      nx            = $urandom;
      ns            = 5'($urandom);
      nop           = int'($urandom_range(0, 2));
      qif.out_ready = rdy;
   endtask

   task automatic cycle();
      logic exp_ready;
      logic issue;
      logic pop;
      @(negedge clock);
      exp_ready = reset_n && !qif.flush && ((mq_data.size() + int'(m_pend)) < DEPTH);
      check("in_ready", 64'(qif.in_ready), 64'(exp_ready));
      check("out_valid", 64'(qif.out_valid), 64'(mq_data.size() != 0));
      check("count", 64'(qif.count), 64'(mq_data.size()));
      if (mq_data.size() != 0) begin
         check("out_data", 64'(qif.out_data), 64'(mq_data[0]));
         check("out_tag", 64'(qif.out_tag), 64'(mq_tag[0]));
`ifdef SHIFTQ_ZFLAG_EN
         check("out_zero", 64'(qif.out_zero), 64'(mq_data[0] == '0));
`endif
      end
      if (int'(qif.count) > max_count) max_count = int'(qif.count);
      if (qif.in_valid && qif.in_ready) accepted++;
      issue = qif.in_valid && exp_ready;
      pop   = (mq_data.size() != 0) && qif.out_ready && !qif.flush;
      @(posedge clock);
      if (qif.flush) begin
         mq_data.delete();
         mq_tag.delete();
      end else begin
         if (pop) begin
            void'(mq_data.pop_front());
            void'(mq_tag.pop_front());
         end
         if (m_pend) begin
            mq_data.push_back(m_pend_res);
            mq_tag.push_back(m_pend_tag);
         end
      end
      m_pend = issue;
      if (issue) begin
         m_pend_res = golden(nx, ns, nop);
         m_pend_tag = qif.in_tag;
      end
      #1;
      qif.shift_z = issue ? m_pend_res : $urandom;
   endtask

   task automatic drain();
      drive(1'b0, 1'b1);
      for (int i = 0; i < 20 && (mq_data.size() != 0 || m_pend); i++) cycle();
      check("drain_empty", 64'(qif.out_valid), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      qif.in_valid  = 1'b0;
      qif.in_tag    = '0;
      qif.flush     = 1'b0;
      qif.shift_z   = '0;
      qif.out_ready = 1'b0;
      nx = '0; ns = '0; nop = 0;
      accepted = 0; max_count = 0;

      // Reset state
      #2;
      check("rst_out_valid", 64'(qif.out_valid), 64'(0));
      check("rst_in_ready", 64'(qif.in_ready), 64'(0));
      check("rst_count", 64'(qif.count), 64'(0));
      check("rst_out_data", 64'(qif.out_data), 64'(0));
      check("rst_out_tag", 64'(qif.out_tag), 64'(0));
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      #1 check("rel_in_ready", 64'(qif.in_ready), 64'(1));

      // Single arithmetic right shift
      qif.in_valid = 1'b1; qif.in_tag = 4'd3; qif.out_ready = 1'b0;
      nx = 32'h8000_0000; ns = 5'd4; nop = 2;
      cycle();
      qif.in_valid = 1'b0;
      check("single_early_valid", 64'(qif.out_valid), 64'(0));
      cycle();
      check("single_valid", 64'(qif.out_valid), 64'(1));
      check("single_data", 64'(qif.out_data), 64'(32'hF800_0000));
      check("single_tag", 64'(qif.out_tag), 64'(3));
      check("single_count", 64'(qif.count), 64'(1));
      drain();

      // Streaming with out_ready held
      max_count = 0;
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 1'b1);
         ns = 5'(i);
         cycle();
      end
      drain();
      check("stream_max_count", 64'(max_count <= 1), 64'(1));

      // Backpressure
      accepted = 0;
      repeat (8) begin drive(1'b1, 1'b0); cycle(); end
      check("bp_accepted", 64'(accepted), 64'(DEPTH));
      check("bp_count", 64'(qif.count), 64'(DEPTH));
      accepted = 0;
      drive(1'b1, 1'b1); cycle();
      repeat (5) begin drive(1'b1, 1'b0); cycle(); end
      check("bp_one_more", 64'(accepted), 64'(1));
      drain();

      // Simultaneous write and pop across pointer wrap
      repeat (3) begin drive(1'b1, 1'b0); cycle(); end
      repeat (10) begin
         drive(1'b1, 1'b1);
         cycle();
         check("simul_count", 64'(qif.count), 64'(2));
      end
      drain();

      // Flush with entries queued and one in flight
      repeat (4) begin drive(1'b1, 1'b0); cycle(); end
      check("flush_pre_count", 64'(qif.count), 64'(3));
      drive(1'b1, 1'b1);
      qif.flush = 1'b1;
      #1 check("flush_in_ready", 64'(qif.in_ready), 64'(0));
      cycle();
      qif.flush = 1'b0;
      qif.in_valid = 1'b0;
      #1;
      check("flush_count", 64'(qif.count), 64'(0));
      check("flush_out_valid", 64'(qif.out_valid), 64'(0));
      check("flush_in_ready_after", 64'(qif.in_ready), 64'(1));
      cycle();
      check("flush_no_stray", 64'(qif.count), 64'(0));

      // Asynchronous reset with the queue half full
      repeat (3) begin drive(1'b1, 1'b0); cycle(); end
      qif.in_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(qif.out_valid), 64'(0));
      check("arst_in_ready", 64'(qif.in_ready), 64'(0));
      check("arst_count", 64'(qif.count), 64'(0));
      check("arst_out_data", 64'(qif.out_data), 64'(0));
      check("arst_out_tag", 64'(qif.out_tag), 64'(0));
`ifdef SHIFTQ_ZFLAG_EN
      check("arst_out_zero", 64'(qif.out_zero), 64'(0));
`endif
      mq_data.delete();
      mq_tag.delete();
      m_pend = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      qif.shift_z = $urandom;
      #1 check("arst_rel_in_ready", 64'(qif.in_ready), 64'(1));
      cycle();
      cycle();

`ifdef SHIFTQ_ZFLAG_EN
      // Zero flag on a result shifted to zero
      qif.in_valid = 1'b1; qif.in_tag = 4'd5; qif.out_ready = 1'b0;
      nx = 32'h0000_0001; ns = 5'd1; nop = 1;
      cycle();
      qif.in_valid = 1'b0;
      cycle();
      check("zflag_out_zero", 64'(qif.out_zero), 64'(1));
      check("zflag_out_data", 64'(qif.out_data), 64'(0));
      drain();
`endif

      // Random traffic with occasional flush
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom), 1'($urandom));
         qif.flush = ($urandom_range(0, 19) == 0);
         cycle();
      end
      qif.flush = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
